// File: rtl/udp_rx_pkg.sv
// Shared types and constants for the UDP receive filter.
// Holds the parser state encoding, header length constants, protocol
// constants and the byte index of the last byte of every checked or
// captured header field (index 0 = first byte of the destination MAC).
package udp_rx_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR     = 3'd1,
        PAYLOAD = 3'd2,
        TAIL    = 3'd3,
        SKIP    = 3'd4
    } rx_state_t;

    localparam int unsigned ETH_HDR_LEN = 14;
    localparam int unsigned IP_HDR_LEN  = 20;
    localparam int unsigned UDP_HDR_LEN = 8;
    localparam int unsigned HDR_TOTAL   = ETH_HDR_LEN + IP_HDR_LEN + UDP_HDR_LEN;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
    localparam logic [7:0]  IP_VER_IHL     = 8'h45;
    localparam logic [47:0] MAC_BCAST      = 48'hFFFF_FFFF_FFFF;

    // Index of the final byte of each field; the field is judged on that cycle.
    localparam logic [5:0] OFF_DST_MAC_END  = 6'd5;
    localparam logic [5:0] OFF_ETYPE_END    = 6'(ETH_HDR_LEN - 1);
    localparam logic [5:0] OFF_VER_IHL      = 6'(ETH_HDR_LEN);
    localparam logic [5:0] OFF_FRAG_END     = 6'(ETH_HDR_LEN + 7);
    localparam logic [5:0] OFF_PROTO        = 6'(ETH_HDR_LEN + 9);
    localparam logic [5:0] OFF_SRC_IP_END   = 6'(ETH_HDR_LEN + 15);
    localparam logic [5:0] OFF_DST_IP_END   = 6'(ETH_HDR_LEN + 19);
    localparam logic [5:0] OFF_SRC_PORT_END = 6'(ETH_HDR_LEN + IP_HDR_LEN + 1);
    localparam logic [5:0] OFF_DST_PORT_END = 6'(ETH_HDR_LEN + IP_HDR_LEN + 3);
    localparam logic [5:0] OFF_UDP_LEN_END  = 6'(ETH_HDR_LEN + IP_HDR_LEN + 5);
    localparam logic [5:0] OFF_HDR_LAST     = 6'(HDR_TOTAL - 1);

endpackage

// File: rtl/udp_rx_filter.sv
// UDP receive filter: parses an Ethernet II / IPv4 / UDP byte stream,
// accepts datagrams addressed to LOCAL_MAC (or broadcast), LOCAL_IP and
// LOCAL_PORT, strips all headers and emits the payload as one contiguous
// registered burst. Padding and FCS are consumed silently.
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   rx_valid, rx_data    input frame bytes, rx_valid high for a whole frame
//   o_valid, o_data      payload byte strobe / byte (1 cycle after input)
//   o_src_ip, o_src_port source of the last accepted datagram
//   pkt_done             pulse with the last payload byte (or after header
//                        when the payload is empty)
//   pkt_drop             pulse on rejection or truncation
module udp_rx_filter
    import udp_rx_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC  = 48'h02_00_00_00_00_01,
    parameter logic [31:0] LOCAL_IP   = 32'hC0A8_0102,
    parameter logic [15:0] LOCAL_PORT = 16'd8080,
    parameter bit          CHECK_MAC  = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        o_valid,
    output logic [7:0]  o_data,
    output logic [31:0] o_src_ip,
    output logic [15:0] o_src_port,
    output logic        pkt_done,
    output logic        pkt_drop
);

    rx_state_t   state_q,    state_d;
    logic [5:0]  idx_q,      idx_d;
    logic [39:0] sr_q,       sr_d;
    logic [15:0] pay_cnt_q,  pay_cnt_d;
    logic        armed_q,    armed_d;
    logic [31:0] hdr_ip_q,   hdr_ip_d;
    logic [15:0] hdr_port_q, hdr_port_d;
    logic        o_valid_q,  o_valid_d;
    logic [7:0]  o_data_q,   o_data_d;
    logic        done_q,     done_d;
    logic        drop_q,     drop_d;
    logic [31:0] src_ip_q,   src_ip_d;
    logic [15:0] src_port_q, src_port_d;

    logic [5:0]  cur_idx;
    logic        hdr_byte;
    logic        field_ok;
    logic [15:0] w16;
    logic [31:0] w32;
    logic [47:0] w48;

    // Field value ending with the byte currently on rx_data.
    assign w16 = {sr_q[7:0],  rx_data};
    assign w32 = {sr_q[23:0], rx_data};
    assign w48 = {sr_q[39:0], rx_data};

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        sr_d       = sr_q;
        pay_cnt_d  = pay_cnt_q;
        armed_d    = armed_q;
        hdr_ip_d   = hdr_ip_q;
        hdr_port_d = hdr_port_q;
        o_valid_d  = 1'b0;
        o_data_d   = o_data_q;
        done_d     = 1'b0;
        drop_d     = 1'b0;
        src_ip_d   = src_ip_q;
        src_port_d = src_port_q;
        hdr_byte   = 1'b0;
        field_ok   = 1'b1;
        // The first byte of a frame arrives while still in IDLE.
        cur_idx    = (state_q == IDLE) ? '0 : idx_q;

        unique case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    // Until rx_valid has been seen low after reset we may be
                    // mid-frame, so the frame is skipped.
                    if (!armed_q) state_d = SKIP;
                    else          hdr_byte = 1'b1;
                end else begin
                    armed_d = 1'b1;
                end
            end
            HDR: begin
                if (rx_valid) begin
                    hdr_byte = 1'b1;
                end else begin
                    drop_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            PAYLOAD: begin
                if (rx_valid) begin
                    o_valid_d = 1'b1;
                    o_data_d  = rx_data;
                    pay_cnt_d = pay_cnt_q - 16'd1;
                    if (pay_cnt_q == 16'd1) begin
                        done_d     = 1'b1;
                        src_ip_d   = hdr_ip_q;
                        src_port_d = hdr_port_q;
                        state_d    = TAIL;
                    end
                end else begin
                    drop_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            TAIL, SKIP: begin
                if (!rx_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (hdr_byte) begin
            sr_d    = {sr_q[31:0], rx_data};
            idx_d   = cur_idx + 6'd1;
            state_d = HDR;
            case (cur_idx)
                OFF_DST_MAC_END:  field_ok = !CHECK_MAC || (w48 == LOCAL_MAC) || (w48 == MAC_BCAST);
                OFF_ETYPE_END:    field_ok = (w16 == ETHERTYPE_IPV4);
                OFF_VER_IHL:      field_ok = (rx_data == IP_VER_IHL);
                // MF flag and fragment offset must both be zero; DF is ignored.
                OFF_FRAG_END:     field_ok = ((w16 & 16'h3FFF) == '0);
                OFF_PROTO:        field_ok = (rx_data == IP_PROTO_UDP);
                OFF_SRC_IP_END:   hdr_ip_d = w32;
                OFF_DST_IP_END:   field_ok = (w32 == LOCAL_IP);
                OFF_SRC_PORT_END: hdr_port_d = w16;
                OFF_DST_PORT_END: field_ok = (w16 == LOCAL_PORT);
                OFF_UDP_LEN_END: begin
                    field_ok  = (w16 >= 16'(UDP_HDR_LEN));
                    pay_cnt_d = w16 - 16'(UDP_HDR_LEN);
                end
                default: ;
            endcase
            if (!field_ok) begin
                drop_d  = 1'b1;
                state_d = SKIP;
            end else if (cur_idx == OFF_HDR_LAST) begin
                if (pay_cnt_q == '0) begin
                    done_d     = 1'b1;
                    src_ip_d   = hdr_ip_q;
                    src_port_d = hdr_port_q;
                    state_d    = TAIL;
                end else begin
                    state_d = PAYLOAD;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            sr_q       <= '0;
            pay_cnt_q  <= '0;
            armed_q    <= 1'b0;
            hdr_ip_q   <= '0;
            hdr_port_q <= '0;
            o_valid_q  <= 1'b0;
            o_data_q   <= '0;
            done_q     <= 1'b0;
            drop_q     <= 1'b0;
            src_ip_q   <= '0;
            src_port_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            sr_q       <= sr_d;
            pay_cnt_q  <= pay_cnt_d;
            armed_q    <= armed_d;
            hdr_ip_q   <= hdr_ip_d;
            hdr_port_q <= hdr_port_d;
            o_valid_q  <= o_valid_d;
            o_data_q   <= o_data_d;
            done_q     <= done_d;
            drop_q     <= drop_d;
            src_ip_q   <= src_ip_d;
            src_port_q <= src_port_d;
        end
    end

    assign o_valid    = o_valid_q;
    assign o_data     = o_data_q;
    assign o_src_ip   = src_ip_q;
    assign o_src_port = src_port_q;
    assign pkt_done   = done_q;
    assign pkt_drop   = drop_q;

endmodule

// File: tb/tb_udp_rx_filter.sv
// Scoreboard bench for udp_rx_filter: frames are built byte by byte,
// expected output events are queued as each frame is issued, and a monitor
// on the falling edge pops and compares every cycle the DUT shows output.
module tb_udp_rx_filter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        o_valid;
    logic [7:0]  o_data;
    logic [31:0] o_src_ip;
    logic [15:0] o_src_port;
    logic        pkt_done;
    logic        pkt_drop;

    localparam logic [47:0] MAC  = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BC   = 48'hFFFF_FFFF_FFFF;
    localparam logic [31:0] IP   = 32'hC0A8_0102;
    localparam logic [15:0] PORT = 16'd8080;

    udp_rx_filter #(
        .LOCAL_MAC  (MAC),
        .LOCAL_IP   (IP),
        .LOCAL_PORT (PORT),
        .CHECK_MAC  (1'b1)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .o_src_ip   (o_src_ip),
        .o_src_port (o_src_port),
        .pkt_done   (pkt_done),
        .pkt_drop   (pkt_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        done;
        logic        drop;
        logic [31:0] ip;
        logic [15:0] port;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] frame[$];
    logic [7:0] pay[$];
    int         checks = 0;
    int         errors = 0;

    always @(negedge clk) begin
        if (rstn && (o_valid || pkt_done || pkt_drop)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got v=%0b d=%02h done=%0b drop=%0b, required no output",
                         o_valid, o_data, pkt_done, pkt_drop);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (o_valid !== e.v || (e.v && o_data !== e.d) || pkt_done !== e.done ||
                    pkt_drop !== e.drop ||
                    (e.done && (o_src_ip !== e.ip || o_src_port !== e.port))) begin
                    errors++;
                    $display("FAIL output_event: got v=%0b d=%02h done=%0b drop=%0b ip=%08h port=%04h, required v=%0b d=%02h done=%0b drop=%0b ip=%08h port=%04h",
                             o_valid, o_data, pkt_done, pkt_drop, o_src_ip, o_src_port,
                             e.v, e.d, e.done, e.drop, e.ip, e.port);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push_b(input logic [47:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) frame.push_back(v[8*i +: 8]);
    endtask

    task automatic build(input logic [47:0] mac, input logic [15:0] et, input logic [7:0] vi,
                         input logic [15:0] frag, input logic [7:0] proto,
                         input logic [31:0] sip, input logic [31:0] dip,
                         input logic [15:0] sp, input logic [15:0] dp, input logic [15:0] ul);
        frame.delete();
        push_b(mac, 6);
        push_b(48'h02_00_00_00_00_99, 6);
        push_b({32'h0, et}, 2);
        push_b({40'h0, vi}, 1);
        push_b(48'h0, 1);                      // TOS
        push_b({32'h0, ul + 16'd20}, 2);        // total length
        push_b(48'h1234, 2);                    // identification
        push_b({32'h0, frag}, 2);
        push_b(48'h40, 1);                      // TTL
        push_b({40'h0, proto}, 1);
        push_b(48'h0, 2);                       // IP checksum
        push_b({16'h0, sip}, 4);
        push_b({16'h0, dip}, 4);
        push_b({32'h0, sp}, 2);
        push_b({32'h0, dp}, 2);
        push_b({32'h0, ul}, 2);
        push_b(48'h0, 2);                       // UDP checksum
        foreach (pay[i]) frame.push_back(pay[i]);
        while (frame.size() < 60) frame.push_back(8'h55);
        push_b(48'hC1C2C3C4, 4);                // FCS
    endtask

    task automatic exp_accept(input int npay, input logic [31:0] ip, input logic [15:0] port);
        if (npay == 0) begin
            exp_q.push_back('{1'b0, 8'h00, 1'b1, 1'b0, ip, port});
        end else begin
            for (int k = 0; k < npay; k++)
                exp_q.push_back('{1'b1, frame[42 + k], (k == npay - 1), 1'b0, ip, port});
        end
    endtask

    task automatic exp_bytes(input int first, input int n);
        for (int k = 0; k < n; k++)
            exp_q.push_back('{1'b1, frame[first + k], 1'b0, 1'b0, 32'h0, 16'h0});
    endtask

    task automatic exp_drop();
        exp_q.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 32'h0, 16'h0});
    endtask

    task automatic send(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rx_valid = 1'b1;
            rx_data  = frame[i];
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic drained(input string name);
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rstn     = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_o_valid",   64'(o_valid),    64'd0);
        chk("reset_o_data",    64'(o_data),     64'd0);
        chk("reset_src_ip",    64'(o_src_ip),   64'd0);
        chk("reset_src_port",  64'(o_src_port), 64'd0);
        chk("reset_pkt_done",  64'(pkt_done),   64'd0);
        chk("reset_pkt_drop",  64'(pkt_drop),   64'd0);
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        // Accepted frame, payload DE AD BE EF.
        pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        build(MAC, 16'h0800, 8'h45, 16'h4000, 8'd17, 32'hC0A8_0164, IP, 16'h04D2, PORT, 16'd12);
        exp_accept(4, 32'hC0A8_0164, 16'h04D2);
        send(frame.size());
        drained("valid_frame");

        // Wrong destination port: dropped, source info held.
        build(MAC, 16'h0800, 8'h45, 16'h0000, 8'd17, 32'h0A0A_0A0A, IP, 16'h1111, 16'd8081, 16'd12);
        exp_drop();
        send(frame.size());
        drained("bad_port");
        chk("held_src_ip",   64'(o_src_ip),   64'hC0A8_0164);
        chk("held_src_port", 64'(o_src_port), 64'h04D2);

        // Broadcast ARP: dropped at ethertype.
        build(BC, 16'h0806, 8'h45, 16'h0000, 8'd17, 32'h0A0A_0A0A, IP, 16'h1111, PORT, 16'd12);
        exp_drop();
        send(frame.size());
        drained("arp");

        // Other header rejections.
        build(48'h02_00_00_00_00_02, 16'h0800, 8'h45, 16'h0, 8'd17, 32'h1, IP, 16'h1, PORT, 16'd12);
        exp_drop(); send(frame.size());
        build(MAC, 16'h0800, 8'h46, 16'h0, 8'd17, 32'h1, IP, 16'h1, PORT, 16'd12);
        exp_drop(); send(frame.size());
        build(MAC, 16'h0800, 8'h45, 16'h2000, 8'd17, 32'h1, IP, 16'h1, PORT, 16'd12);
        exp_drop(); send(frame.size());
        build(MAC, 16'h0800, 8'h45, 16'h0001, 8'd17, 32'h1, IP, 16'h1, PORT, 16'd12);
        exp_drop(); send(frame.size());
        build(MAC, 16'h0800, 8'h45, 16'h0, 8'd6, 32'h1, IP, 16'h1, PORT, 16'd12);
        exp_drop(); send(frame.size());
        build(MAC, 16'h0800, 8'h45, 16'h0, 8'd17, 32'h1, 32'hC0A8_0103, 16'h1, PORT, 16'd12);
        exp_drop(); send(frame.size());
        build(MAC, 16'h0800, 8'h45, 16'h0, 8'd17, 32'h1, IP, 16'h1, PORT, 16'd7);
        exp_drop(); send(frame.size());
        drained("header_rejects");

        // Zero-length payload: done with no o_valid, padding/FCS silent.
        pay.delete();
        build(MAC, 16'h0800, 8'h45, 16'h0, 8'd17, 32'h0A00_0001, IP, 16'h1111, PORT, 16'd8);
        exp_accept(0, 32'h0A00_0001, 16'h1111);
        send(frame.size());
        drained("udp_len_8");
        chk("len8_src_ip", 64'(o_src_ip), 64'h0A00_0001);

        // Broadcast destination MAC with otherwise valid datagram is accepted.
        pay = '{8'h01, 8'h02};
        build(BC, 16'h0800, 8'h45, 16'h0, 8'd17, 32'hAC10_0005, IP, 16'h2222, PORT, 16'd10);
        exp_accept(2, 32'hAC10_0005, 16'h2222);
        send(frame.size());
        drained("bcast_accept");

        // Truncated after payload byte 2 of 4, then a good frame.
        pay = '{8'h11, 8'h22, 8'h33, 8'h44};
        build(MAC, 16'h0800, 8'h45, 16'h0, 8'd17, 32'h0B0B_0B0B, IP, 16'h3333, PORT, 16'd12);
        exp_bytes(42, 2);
        exp_drop();
        send(44);
        pay = '{8'hA1, 8'hB2, 8'hC3};
        build(MAC, 16'h0800, 8'h45, 16'h0, 8'd17, 32'h0C0C_0C0C, IP, 16'h4444, PORT, 16'd11);
        exp_accept(3, 32'h0C0C_0C0C, 16'h4444);
        send(frame.size());
        drained("truncated_payload");

        // Truncated inside the header.
        build(MAC, 16'h0800, 8'h45, 16'h0, 8'd17, 32'h0D0D_0D0D, IP, 16'h5555, PORT, 16'd12);
        exp_drop();
        send(30);
        drained("truncated_header");

        // UDP length larger than the frame: all remaining bytes then drop.
        pay = '{8'h91, 8'h92, 8'h93, 8'h94};
        build(MAC, 16'h0800, 8'h45, 16'h0, 8'd17, 32'h0E0E_0E0E, IP, 16'h6666, PORT, 16'd100);
        exp_bytes(42, frame.size() - 42);
        exp_drop();
        send(frame.size());
        drained("overlong_len");

        // Reset asserted mid-frame and released while rx_valid is high.
        pay = '{8'h77, 8'h88};
        build(MAC, 16'h0800, 8'h45, 16'h0, 8'd17, 32'h0F0F_0F0F, IP, 16'h7777, PORT, 16'd10);
        for (int i = 0; i < frame.size(); i++) begin
            @(posedge clk); #1;
            rx_valid = 1'b1;
            rx_data  = frame[i];
            if (i == 20) rstn = 1'b0;
            if (i == 24) rstn = 1'b1;
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        drained("reset_mid_frame");
        chk("midreset_src_ip",   64'(o_src_ip),   64'd0);
        chk("midreset_src_port", 64'(o_src_port), 64'd0);
        exp_accept(2, 32'h0F0F_0F0F, 16'h7777);
        send(frame.size());
        drained("after_reset_frame");

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
